// File: rtl/traffic_sequencer_n_if.sv
// -----------------------------------------------------------------------------
// traffic_sequencer_n_if
// Bundles the control inputs and lamp outputs of traffic_sequencer_n.
//   enable         : run request
//   service_btn    : level, service-mode request
//   ped_request    : pedestrian request (pulse is latched inside the sequencer)
//   green/yellow/red : per-direction lamps, N_DIR bits each
//   ped_walk       : pedestrian walk lamp
//   service_active : high while in service (blinking yellow) mode
//   phase_idx      : current/next direction index
//   cycle_done     : one-cycle pulse when phase_idx wraps to 0
// Modports: slave = sequencer side, master = controller/testbench side.
// -----------------------------------------------------------------------------
interface traffic_sequencer_n_if #(
  parameter int N_DIR = 4
);
  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  logic             enable;
  logic             service_btn;
  logic             ped_request;
  logic [N_DIR-1:0] green;
  logic [N_DIR-1:0] yellow;
  logic [N_DIR-1:0] red;
  logic             ped_walk;
  logic             service_active;
  logic [IDX_W-1:0] phase_idx;
  logic             cycle_done;

  modport slave (
    input  enable, service_btn, ped_request,
    output green, yellow, red, ped_walk, service_active, phase_idx, cycle_done
  );

  modport master (
    output enable, service_btn, ped_request,
    input  green, yellow, red, ped_walk, service_active, phase_idx, cycle_done
  );
endinterface

// File: rtl/traffic_sequencer_n.sv
// -----------------------------------------------------------------------------
// traffic_sequencer_n
// N-direction traffic-light sequencer: green -> yellow -> all-red per direction,
// optional pedestrian walk slot after a clearance, and a blinking-yellow
// service mode. Contains its own tick divider (DIV_FACTOR clk cycles per tick);
// every phase dwell is a whole number of ticks.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : traffic_sequencer_n_if.slave (control inputs, lamp outputs)
// All outputs are registered; they are decoded from the next-state values so
// they change on the same edge that registers the new state.
// -----------------------------------------------------------------------------
module traffic_sequencer_n #(
  parameter int N_DIR      = 4,
  parameter int DIV_FACTOR = 10,
  parameter int CNT_W      = 5,
  parameter int T_GREEN    = 8,
  parameter int T_YELLOW   = 3,
  parameter int T_ALL_RED  = 2,
  parameter int T_PED      = 6
) (
  input logic                  clk,
  input logic                  rst,
  traffic_sequencer_n_if.slave bus
);

  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;
  localparam int DIV_W = $clog2(DIV_FACTOR);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV_FACTOR - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(T_PED - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DIR - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GREEN   = 3'd1,
    S_YELLOW  = 3'd2,
    S_CLR     = 3'd3,
    S_PED     = 3'd4,
    S_PED_CLR = 3'd5,
    S_SERVICE = 3'd6
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_blink;
  logic             r_ped_pending;
  logic [N_DIR-1:0] r_green;
  logic [N_DIR-1:0] r_yellow;
  logic [N_DIR-1:0] r_red;
  logic             r_ped_walk;
  logic             r_service_active;
  logic             r_cycle_done;

  state_t           w_next_state;
  logic             w_tick;
  logic             w_at_last;
  logic             w_dwell_done;
  logic             w_entry;
  logic             w_wrap;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_blink_next;
  logic [N_DIR-1:0] w_onehot;
  logic [N_DIR-1:0] w_green_d;
  logic [N_DIR-1:0] w_yellow_d;
  logic [N_DIR-1:0] w_red_d;
  logic             w_ped_walk_d;
  logic             w_service_active_d;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_dwell_done = w_tick && w_at_last;
  assign w_entry      = (w_next_state != r_state);
  assign w_wrap       = (r_state == S_YELLOW) && w_dwell_done && (r_idx == IDX_LAST);

  // Selects the last-tick count of the current state's dwell.
  always_comb begin
    w_at_last = 1'b0;
    case (r_state)
      S_GREEN:   w_at_last = (r_cnt == GREEN_LAST);
      S_YELLOW:  w_at_last = (r_cnt == YELLOW_LAST);
      S_CLR:     w_at_last = (r_cnt == CLR_LAST);
      S_PED:     w_at_last = (r_cnt == PED_LAST);
      S_PED_CLR: w_at_last = (r_cnt == CLR_LAST);
      default:   w_at_last = 1'b0;
    endcase
  end

  // Next-state logic, together with the next direction index and blink phase.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.service_btn)  w_next_state = S_SERVICE;
        else if (bus.enable)  w_next_state = S_GREEN;
        else                  w_next_state = S_IDLE;
      end
      S_GREEN: begin
        // Service truncates green immediately.
        if (bus.service_btn || w_dwell_done) w_next_state = S_YELLOW;
        else                                 w_next_state = S_GREEN;
      end
      S_YELLOW: begin
        if (w_dwell_done) w_next_state = S_CLR;
        else              w_next_state = S_YELLOW;
      end
      S_CLR: begin
        if (w_dwell_done) begin
          if (bus.service_btn)     w_next_state = S_SERVICE;
          else if (!bus.enable)    w_next_state = S_IDLE;
          else if (r_ped_pending)  w_next_state = S_PED;
          else                     w_next_state = S_GREEN;
        end else begin
          w_next_state = S_CLR;
        end
      end
      S_PED: begin
        if (w_dwell_done) w_next_state = S_PED_CLR;
        else              w_next_state = S_PED;
      end
      S_PED_CLR: begin
        if (w_dwell_done) begin
          if (bus.service_btn) w_next_state = S_SERVICE;
          else                 w_next_state = S_GREEN;
        end else begin
          w_next_state = S_PED_CLR;
        end
      end
      S_SERVICE: begin
        if (!bus.service_btn) w_next_state = S_PED_CLR;
        else                  w_next_state = S_SERVICE;
      end
      default: w_next_state = S_IDLE;
    endcase

    // Direction advances as yellow ends; leaving service restarts at 0.
    w_idx_next = r_idx;
    if ((r_state == S_YELLOW) && w_dwell_done) begin
      if (r_idx == IDX_LAST) w_idx_next = {IDX_W{1'b0}};
      else                   w_idx_next = r_idx + IDX_W'(1);
    end else if ((r_state == S_SERVICE) && !bus.service_btn) begin
      w_idx_next = {IDX_W{1'b0}};
    end else begin
      w_idx_next = r_idx;
    end

    w_blink_next = r_blink;
    if ((w_next_state == S_SERVICE) && w_entry) w_blink_next = 1'b1;
    else if ((r_state == S_SERVICE) && w_tick)  w_blink_next = ~r_blink;
    else                                        w_blink_next = r_blink;
  end

  // State, direction index and blink registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= {IDX_W{1'b0}};
      r_blink <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_idx_next;
      r_blink <= w_blink_next;
    end
  end

  // Tick divider and dwell counter; both restart on every state entry.
  always_ff @(posedge clk) begin
    if (rst || w_entry) begin
      r_div <= {DIV_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_tick) begin
      r_div <= {DIV_W{1'b0}};
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
      r_cnt <= r_cnt;
    end
  end

  // Pedestrian request latch; entering PED clears it and wins over a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped_pending <= 1'b0;
    end else if (w_entry && (w_next_state == S_PED)) begin
      r_ped_pending <= 1'b0;
    end else if (bus.ped_request) begin
      r_ped_pending <= 1'b1;
    end else begin
      r_ped_pending <= r_ped_pending;
    end
  end

  // Lamp decode from the next state so registered lamps track the state edge.
  always_comb begin
    w_onehot           = {N_DIR{1'b0}};
    w_green_d          = {N_DIR{1'b0}};
    w_yellow_d         = {N_DIR{1'b0}};
    w_red_d            = {N_DIR{1'b1}};
    w_ped_walk_d       = 1'b0;
    w_service_active_d = 1'b0;
    for (int i = 0; i < N_DIR; i++) begin
      w_onehot[i] = (w_idx_next == IDX_W'(i));
    end
    case (w_next_state)
      S_GREEN: begin
        w_green_d = w_onehot;
        w_red_d   = ~w_onehot;
      end
      S_YELLOW: begin
        w_yellow_d = w_onehot;
        w_red_d    = ~w_onehot;
      end
      S_PED: begin
        w_ped_walk_d = 1'b1;
      end
      S_SERVICE: begin
        w_yellow_d         = {N_DIR{w_blink_next}};
        w_red_d            = {N_DIR{1'b0}};
        w_service_active_d = 1'b1;
      end
      default: begin
        w_red_d = {N_DIR{1'b1}};
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_green          <= {N_DIR{1'b0}};
      r_yellow         <= {N_DIR{1'b0}};
      r_red            <= {N_DIR{1'b1}};
      r_ped_walk       <= 1'b0;
      r_service_active <= 1'b0;
      r_cycle_done     <= 1'b0;
    end else begin
      r_green          <= w_green_d;
      r_yellow         <= w_yellow_d;
      r_red            <= w_red_d;
      r_ped_walk       <= w_ped_walk_d;
      r_service_active <= w_service_active_d;
      r_cycle_done     <= w_wrap;
    end
  end

  assign bus.green          = r_green;
  assign bus.yellow         = r_yellow;
  assign bus.red            = r_red;
  assign bus.ped_walk       = r_ped_walk;
  assign bus.service_active = r_service_active;
  assign bus.phase_idx      = r_idx;
  assign bus.cycle_done     = r_cycle_done;

endmodule

// File: tb/tb_traffic_sequencer_n.sv
// -----------------------------------------------------------------------------
// tb_traffic_sequencer_n
// Directed bench for traffic_sequencer_n with N_DIR=4, DIV_FACTOR=2,
// T_GREEN=3, T_YELLOW=2, T_ALL_RED=1, T_PED=2: green 6 cycles, yellow 4,
// clearance 2, walk 4, one slot 12 cycles, one rotation 48 cycles.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_traffic_sequencer_n;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  traffic_sequencer_n_if #(.N_DIR(4)) bus ();

  traffic_sequencer_n #(
    .N_DIR(4), .DIV_FACTOR(2), .CNT_W(5),
    .T_GREEN(3), .T_YELLOW(2), .T_ALL_RED(1), .T_PED(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs for n consecutive cycles, advancing one cycle after each.
  task automatic expect_cycles(input string tag, input int n,
                               input logic [3:0] g, input logic [3:0] y, input logic [3:0] r,
                               input logic pw, input logic sa, input logic [1:0] idx,
                               input logic cd_first);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s/%0d green", tag, i),  {28'd0, bus.green},  {28'd0, g});
      chk($sformatf("%s/%0d yellow", tag, i), {28'd0, bus.yellow}, {28'd0, y});
      chk($sformatf("%s/%0d red", tag, i),    {28'd0, bus.red},    {28'd0, r});
      chk($sformatf("%s/%0d ped_walk", tag, i), {31'd0, bus.ped_walk}, {31'd0, pw});
      chk($sformatf("%s/%0d service", tag, i), {31'd0, bus.service_active}, {31'd0, sa});
      chk($sformatf("%s/%0d phase_idx", tag, i), {30'd0, bus.phase_idx}, {30'd0, idx});
      chk($sformatf("%s/%0d cycle_done", tag, i), {31'd0, bus.cycle_done},
          {31'd0, (i == 0) ? cd_first : 1'b0});
      step();
    end
  endtask

  task automatic ph_green(input int d, input int n);
    logic [3:0] oh;
    oh = 4'(1 << d);
    expect_cycles($sformatf("green%0d", d), n, oh, 4'h0, ~oh, 1'b0, 1'b0, 2'(d), 1'b0);
  endtask

  task automatic ph_yellow(input int d, input int n);
    logic [3:0] oh;
    oh = 4'(1 << d);
    expect_cycles($sformatf("yellow%0d", d), n, 4'h0, oh, ~oh, 1'b0, 1'b0, 2'(d), 1'b0);
  endtask

  task automatic ph_clr(input int idx, input logic cd, input int n);
    expect_cycles("clr", n, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'(idx), cd);
  endtask

  task automatic ph_ped(input int idx, input int n);
    expect_cycles("ped", n, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 2'(idx), 1'b0);
  endtask

  task automatic ph_pedclr(input int idx, input int n);
    expect_cycles("ped_clr", n, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'(idx), 1'b0);
  endtask

  task automatic ph_idle(input int idx, input int n);
    expect_cycles("idle", n, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 2'(idx), 1'b0);
  endtask

  task automatic ph_svc(input logic [3:0] y, input int idx, input int n);
    expect_cycles("service", n, 4'h0, y, 4'h0, 1'b0, 1'b1, 2'(idx), 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.service_btn = 1'b0;
    bus.ped_request = 1'b0;

    // Reset and idle
    repeat (3) step();
    ph_idle(0, 1);
    rst = 1'b0;
    ph_idle(0, 3);

    // Start: enable sampled at the next edge, green[0] right after it
    bus.enable = 1'b1;
    ph_idle(0, 1);

    // Full rotation, cycle_done on the first clearance cycle after yellow[3]
    for (int d = 0; d < 4; d++) begin
      ph_green(d, 6);
      ph_yellow(d, 4);
      ph_clr((d + 1) % 4, (d == 3), 2);
    end
    // Second rotation starts 48 cycles later
    ph_green(0, 6);
    ph_yellow(0, 4);
    ph_clr(1, 1'b0, 2);

    // Pedestrian pulse during green[1]
    bus.ped_request = 1'b1;
    ph_green(1, 1);
    bus.ped_request = 1'b0;
    ph_green(1, 5);
    ph_yellow(1, 4);
    ph_clr(2, 1'b0, 2);
    ph_ped(2, 4);
    ph_pedclr(2, 2);

    // Service during green[2]: green truncated, then blinking yellow
    ph_green(2, 2);
    bus.service_btn = 1'b1;
    ph_green(2, 1);
    ph_yellow(2, 4);
    ph_clr(3, 1'b0, 2);
    ph_svc(4'hF, 3, 2);
    ph_svc(4'h0, 3, 2);
    ph_svc(4'hF, 3, 2);
    bus.service_btn = 1'b0;
    ph_svc(4'h0, 3, 1);
    ph_pedclr(0, 2);

    // Disable during green[1]: finish through clearance, idle, resume at 2
    ph_green(0, 6);
    ph_yellow(0, 4);
    ph_clr(1, 1'b0, 2);
    ph_green(1, 2);
    bus.enable = 1'b0;
    ph_green(1, 4);
    ph_yellow(1, 4);
    ph_clr(2, 1'b0, 2);
    ph_idle(2, 3);
    bus.enable = 1'b1;
    ph_idle(2, 1);

    // Reset during a walk slot at direction 3; a request made in the walk is dropped
    bus.ped_request = 1'b1;
    ph_green(2, 1);
    bus.ped_request = 1'b0;
    ph_green(2, 5);
    ph_yellow(2, 4);
    ph_clr(3, 1'b0, 2);
    ph_ped(3, 1);
    bus.ped_request = 1'b1;
    ph_ped(3, 1);
    bus.ped_request = 1'b0;
    rst = 1'b1;
    ph_ped(3, 1);
    rst = 1'b0;
    bus.enable = 1'b0;
    ph_idle(0, 2);
    bus.enable = 1'b1;
    ph_idle(0, 1);
    ph_green(0, 6);
    ph_yellow(0, 4);
    ph_clr(1, 1'b0, 2);
    ph_green(1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
